stack_req_ctrl: RTL and testbench

- Issue-side controller for the dual-port PUSH/POP stack in the in-order superscalar CPU.
- Sits in EX. Takes the stack requests of the two issued instruction slots and drives push0/pop0/push1/pop1 to the stack.
- Keeps a shadow occupancy count equal to the stack pointer. Gates each op against full/empty, raises overflow/underflow flags aligned with stack0_EX_DM/stack1_EX_DM, and holds a trap state until software clears it.

---
 rtl/stack_req_ctrl_if.sv | 42 ++++
 rtl/stack_req_ctrl.sv | 105 ++++++++++
 tb/tb_stack_req_ctrl.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/stack_req_ctrl_if.sv
// Request/command bundle between the EX issue slots, the stack controller and the stack.
// The master side drives the slot requests; the slave side (the controller) returns commands and status.
interface stack_req_ctrl_if #(
   parameter int OCC_W = 11
);
   logic             vld0;
   logic             vld1;
   logic             push_req0;
   logic             pop_req0;
   logic             push_req1;
   logic             pop_req1;
   logic             stall_in;
   logic             flush;
   logic             trap_clr;
   logic             push0;
   logic             pop0;
   logic             push1;
   logic             pop1;
   logic             ovf0;
   logic             ovf1;
   logic             unf0;
   logic             unf1;
   logic             ill0;
   logic             ill1;
   logic             trap;
   logic [OCC_W-1:0] occ;
   logic [OCC_W-1:0] hwm;

   modport master (
      output vld0, vld1, push_req0, pop_req0, push_req1, pop_req1,
             stall_in, flush, trap_clr,
      input  push0, pop0, push1, pop1, ovf0, ovf1, unf0, unf1,
             ill0, ill1, trap, occ, hwm
   );

   modport slave (
      input  vld0, vld1, push_req0, pop_req0, push_req1, pop_req1,
             stall_in, flush, trap_clr,
      output push0, pop0, push1, pop1, ovf0, ovf1, unf0, unf1,
             ill0, ill1, trap, occ, hwm
   );
endinterface

// File: rtl/stack_req_ctrl.sv
// EX-stage issue controller for the dual-port PUSH/POP stack: gates both slots against
// full/empty using a shadow occupancy count and latches a trap on any fault.
module stack_req_ctrl #(
   parameter int DEPTH = 1024,
   parameter int OCC_W = 11
) (
   input logic           clk,
   input logic           rst_n,
   stack_req_ctrl_if.slave bus
);
   localparam logic [0:0] RUN  = 1'b0;
   localparam logic [0:0] TRAP = 1'b1;
   localparam logic [OCC_W-1:0] FULL = OCC_W'(DEPTH);

   logic [0:0]       state;
   logic [0:0]       state_nxt;
   logic [OCC_W-1:0] occ;
   logic [OCC_W-1:0] hwm;
   logic [OCC_W-1:0] occ_mid;
   logic [OCC_W-1:0] occ_nxt;
   logic [OCC_W-1:0] hwm_nxt;
   logic             active;
   logic             req_push0, req_pop0, req_push1, req_pop1;
   logic             iss_push0, iss_pop0, iss_push1, iss_pop1;
   logic             ill0_c, ill1_c;
   logic             ovf0_c, ovf1_c, unf0_c, unf1_c;
   logic             fault;
   logic             ovf0, ovf1, unf0, unf1, ill0, ill1;

   // rst_n is folded in so commands drop combinationally while reset is held.
   assign active = rst_n & ~bus.stall_in & ~bus.flush & (state == RUN);

   assign ill0_c = active & bus.vld0 & bus.push_req0 & bus.pop_req0;
   assign ill1_c = active & bus.vld1 & bus.push_req1 & bus.pop_req1;

   assign req_push0 = active & bus.vld0 & bus.push_req0 & ~bus.pop_req0;
   assign req_pop0  = active & bus.vld0 & bus.pop_req0  & ~bus.push_req0;
   assign req_push1 = active & bus.vld1 & bus.push_req1 & ~bus.pop_req1;
   assign req_pop1  = active & bus.vld1 & bus.pop_req1  & ~bus.push_req1;

   // Slot 0 sees the current count and slot 1 the count after slot 0, except that
   // push0+pop1 always issues both, so the push is allowed even when full.
   always_comb begin
      iss_push0 = req_push0 & ((occ != FULL) | req_pop1);
      iss_pop0  = req_pop0 & (occ != '0);
      occ_mid   = occ + OCC_W'(iss_push0) - OCC_W'(iss_pop0);
      iss_push1 = req_push1 & (occ_mid != FULL);
      iss_pop1  = req_pop1 & ((occ_mid != '0) | req_push0);
      occ_nxt   = occ_mid + OCC_W'(iss_push1) - OCC_W'(iss_pop1);
      hwm_nxt   = (occ_nxt > hwm) ? occ_nxt : hwm;
   end

   assign ovf0_c = req_push0 & ~iss_push0;
   assign unf0_c = req_pop0  & ~iss_pop0;
   assign ovf1_c = req_push1 & ~iss_push1;
   assign unf1_c = req_pop1  & ~iss_pop1;
   assign fault  = ovf0_c | ovf1_c | unf0_c | unf1_c | ill0_c | ill1_c;

   // A new fault takes priority over trap_clr.
   always_comb begin
      state_nxt = state;
      if (fault)
         state_nxt = TRAP;
      else if ((state == TRAP) && bus.trap_clr)
         state_nxt = RUN;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RUN;
         occ   <= '0;
         hwm   <= '0;
         ovf0  <= 1'b0;
         ovf1  <= 1'b0;
         unf0  <= 1'b0;
         unf1  <= 1'b0;
         ill0  <= 1'b0;
         ill1  <= 1'b0;
      end else begin
         state <= state_nxt;
         occ   <= occ_nxt;
         hwm   <= hwm_nxt;
         ovf0  <= ovf0_c;
         ovf1  <= ovf1_c;
         unf0  <= unf0_c;
         unf1  <= unf1_c;
         ill0  <= ill0_c;
         ill1  <= ill1_c;
      end
   end

   assign bus.push0 = iss_push0;
   assign bus.pop0  = iss_pop0;
   assign bus.push1 = iss_push1;
   assign bus.pop1  = iss_pop1;
   assign bus.ovf0  = ovf0;
   assign bus.ovf1  = ovf1;
   assign bus.unf0  = unf0;
   assign bus.unf1  = unf1;
   assign bus.ill0  = ill0;
   assign bus.ill1  = ill1;
   assign bus.trap  = (state == TRAP);
   assign bus.occ   = occ;
   assign bus.hwm   = hwm;
endmodule

// File: tb/tb_stack_req_ctrl.sv
// Directed bench for stack_req_ctrl: each task drives one scenario and checks
// hand-computed commands, flags and occupancy.
module tb_stack_req_ctrl;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   stack_req_ctrl_if #(.OCC_W(11)) bus_if ();

   stack_req_ctrl #(.DEPTH(1024), .OCC_W(11)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive(input logic v0, u0, o0, v1, u1, o1, st, fl, clr);
      bus_if.vld0      = v0;
      bus_if.push_req0 = u0;
      bus_if.pop_req0  = o0;
      bus_if.vld1      = v1;
      bus_if.push_req1 = u1;
      bus_if.pop_req1  = o1;
      bus_if.stall_in  = st;
      bus_if.flush     = fl;
      bus_if.trap_clr  = clr;
   endtask

   // One issue cycle: inputs applied at negedge, then the active posedge.
   task automatic cycle(input logic v0, u0, o0, v1, u1, o1, st, fl, clr);
      @(negedge clk);
      drive(v0, u0, o0, v1, u1, o1, st, fl, clr);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      checks++; if (bus_if.occ !== 11'd0) begin errors++; $display("FAIL reset_occ got %0d exp 0", bus_if.occ); end
      checks++; if (bus_if.hwm !== 11'd0) begin errors++; $display("FAIL reset_hwm got %0d exp 0", bus_if.hwm); end
      checks++; if (bus_if.trap !== 1'b0) begin errors++; $display("FAIL reset_trap got %0b exp 0", bus_if.trap); end
      checks++; if ({bus_if.ovf0, bus_if.ovf1, bus_if.unf0, bus_if.unf1, bus_if.ill0, bus_if.ill1} !== 6'b0)
         begin errors++; $display("FAIL reset_flags got %b exp 000000", {bus_if.ovf0, bus_if.ovf1, bus_if.unf0, bus_if.unf1, bus_if.ill0, bus_if.ill1}); end
   endtask

   task automatic test_push_fill();
      int hi = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
         #1;
         if (bus_if.push0 === 1'b1) hi++;
         @(posedge clk);
         #1;
      end
      checks++; if (hi !== 5) begin errors++; $display("FAIL fill_push0_cycles got %0d exp 5", hi); end
      checks++; if (bus_if.occ !== 11'd5) begin errors++; $display("FAIL fill_occ got %0d exp 5", bus_if.occ); end
      checks++; if (bus_if.hwm !== 11'd5) begin errors++; $display("FAIL fill_hwm got %0d exp 5", bus_if.hwm); end
      checks++; if ({bus_if.ovf0, bus_if.ovf1, bus_if.trap} !== 3'b000) begin errors++; $display("FAIL fill_flags got %b exp 000", {bus_if.ovf0, bus_if.ovf1, bus_if.trap}); end
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 509; i++) cycle(1, 1, 0, 1, 1, 0, 0, 0, 0);
      checks++; if (bus_if.occ !== 11'd1023) begin errors++; $display("FAIL ovf_prefill got %0d exp 1023", bus_if.occ); end
      @(negedge clk);
      drive(1, 1, 0, 1, 1, 0, 0, 0, 0);
      #1;
      checks++; if ({bus_if.push0, bus_if.push1} !== 2'b10) begin errors++; $display("FAIL ovf_cmds got %b exp 10", {bus_if.push0, bus_if.push1}); end
      @(posedge clk);
      #1;
      checks++; if ({bus_if.ovf0, bus_if.ovf1} !== 2'b01) begin errors++; $display("FAIL ovf_flags got %b exp 01", {bus_if.ovf0, bus_if.ovf1}); end
      checks++; if (bus_if.trap !== 1'b1) begin errors++; $display("FAIL ovf_trap got %0b exp 1", bus_if.trap); end
      checks++; if (bus_if.occ !== 11'd1024) begin errors++; $display("FAIL ovf_occ got %0d exp 1024", bus_if.occ); end
      checks++; if (bus_if.hwm !== 11'd1024) begin errors++; $display("FAIL ovf_hwm got %0d exp 1024", bus_if.hwm); end
      @(negedge clk);
      drive(1, 1, 0, 1, 1, 0, 0, 0, 0);
      #1;
      checks++; if ({bus_if.push0, bus_if.push1} !== 2'b00) begin errors++; $display("FAIL trap_cmds got %b exp 00", {bus_if.push0, bus_if.push1}); end
      @(posedge clk);
      #1;
      checks++; if ({bus_if.ovf0, bus_if.ovf1, bus_if.trap} !== 3'b001) begin errors++; $display("FAIL trap_hold got %b exp 001", {bus_if.ovf0, bus_if.ovf1, bus_if.trap}); end
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
      checks++; if (bus_if.trap !== 1'b0) begin errors++; $display("FAIL ovf_clr got %0b exp 0", bus_if.trap); end
      @(negedge clk);
      drive(1, 1, 0, 1, 1, 0, 0, 0, 0);
      #1;
      checks++; if ({bus_if.push0, bus_if.push1} !== 2'b00) begin errors++; $display("FAIL full_pair_cmds got %b exp 00", {bus_if.push0, bus_if.push1}); end
      @(posedge clk);
      #1;
      checks++; if ({bus_if.ovf0, bus_if.ovf1, bus_if.trap} !== 3'b111) begin errors++; $display("FAIL full_pair_flags got %b exp 111", {bus_if.ovf0, bus_if.ovf1, bus_if.trap}); end
      checks++; if (bus_if.occ !== 11'd1024) begin errors++; $display("FAIL full_pair_occ got %0d exp 1024", bus_if.occ); end
   endtask

   task automatic test_underflow();
      do_reset();
      cycle(1, 1, 0, 0, 0, 0, 0, 0, 0);
      checks++; if (bus_if.occ !== 11'd1) begin errors++; $display("FAIL unf_prefill got %0d exp 1", bus_if.occ); end
      @(negedge clk);
      drive(1, 0, 1, 1, 0, 1, 0, 0, 0);
      #1;
      checks++; if ({bus_if.pop0, bus_if.pop1} !== 2'b10) begin errors++; $display("FAIL unf_cmds got %b exp 10", {bus_if.pop0, bus_if.pop1}); end
      @(posedge clk);
      #1;
      checks++; if ({bus_if.unf0, bus_if.unf1, bus_if.trap} !== 3'b011) begin errors++; $display("FAIL unf_flags got %b exp 011", {bus_if.unf0, bus_if.unf1, bus_if.trap}); end
      checks++; if (bus_if.occ !== 11'd0) begin errors++; $display("FAIL unf_occ got %0d exp 0", bus_if.occ); end
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
      checks++; if ({bus_if.unf1, bus_if.trap} !== 2'b00) begin errors++; $display("FAIL unf_clr got %b exp 00", {bus_if.unf1, bus_if.trap}); end
      @(negedge clk);
      drive(1, 0, 1, 1, 0, 1, 0, 0, 0);
      #1;
      checks++; if ({bus_if.pop0, bus_if.pop1} !== 2'b00) begin errors++; $display("FAIL empty_pair_cmds got %b exp 00", {bus_if.pop0, bus_if.pop1}); end
      @(posedge clk);
      #1;
      checks++; if ({bus_if.unf0, bus_if.unf1, bus_if.trap} !== 3'b111) begin errors++; $display("FAIL empty_pair_flags got %b exp 111", {bus_if.unf0, bus_if.unf1, bus_if.trap}); end
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
      @(negedge clk);
      drive(1, 0, 1, 1, 1, 0, 0, 0, 0);
      #1;
      checks++; if ({bus_if.pop0, bus_if.push1} !== 2'b01) begin errors++; $display("FAIL pop_push_empty_cmds got %b exp 01", {bus_if.pop0, bus_if.push1}); end
      @(posedge clk);
      #1;
      checks++; if ({bus_if.unf0, bus_if.unf1, bus_if.trap} !== 3'b101) begin errors++; $display("FAIL pop_push_empty_flags got %b exp 101", {bus_if.unf0, bus_if.unf1, bus_if.trap}); end
      checks++; if (bus_if.occ !== 11'd1) begin errors++; $display("FAIL pop_push_empty_occ got %0d exp 1", bus_if.occ); end
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
   endtask

   task automatic test_mixed();
      cycle(1, 1, 0, 1, 1, 0, 0, 0, 0);
      checks++; if (bus_if.occ !== 11'd3) begin errors++; $display("FAIL mix_prefill got %0d exp 3", bus_if.occ); end
      @(negedge clk);
      drive(1, 1, 0, 1, 0, 1, 0, 0, 0);
      #1;
      checks++; if ({bus_if.push0, bus_if.pop1} !== 2'b11) begin errors++; $display("FAIL push_pop_cmds got %b exp 11", {bus_if.push0, bus_if.pop1}); end
      @(posedge clk);
      #1;
      checks++; if (bus_if.occ !== 11'd3) begin errors++; $display("FAIL push_pop_occ got %0d exp 3", bus_if.occ); end
      checks++; if ({bus_if.ovf0, bus_if.ovf1, bus_if.unf0, bus_if.unf1, bus_if.trap} !== 5'b0) begin errors++; $display("FAIL push_pop_flags got %b exp 00000", {bus_if.ovf0, bus_if.ovf1, bus_if.unf0, bus_if.unf1, bus_if.trap}); end
      @(negedge clk);
      drive(1, 0, 1, 1, 1, 0, 0, 0, 0);
      #1;
      checks++; if ({bus_if.pop0, bus_if.push1} !== 2'b11) begin errors++; $display("FAIL pop_push_cmds got %b exp 11", {bus_if.pop0, bus_if.push1}); end
      @(posedge clk);
      #1;
      checks++; if (bus_if.occ !== 11'd3) begin errors++; $display("FAIL pop_push_occ got %0d exp 3", bus_if.occ); end
   endtask

   task automatic test_illegal();
      cycle(1, 1, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      drive(1, 1, 1, 0, 0, 0, 0, 0, 0);
      #1;
      checks++; if ({bus_if.push0, bus_if.pop0, bus_if.push1, bus_if.pop1} !== 4'b0) begin errors++; $display("FAIL ill_cmds got %b exp 0000", {bus_if.push0, bus_if.pop0, bus_if.push1, bus_if.pop1}); end
      @(posedge clk);
      #1;
      checks++; if ({bus_if.ill0, bus_if.ill1, bus_if.trap} !== 3'b101) begin errors++; $display("FAIL ill_flags got %b exp 101", {bus_if.ill0, bus_if.ill1, bus_if.trap}); end
      checks++; if (bus_if.occ !== 11'd4) begin errors++; $display("FAIL ill_occ got %0d exp 4", bus_if.occ); end
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
   endtask

   task automatic test_stall_flush();
      do_reset();
      cycle(1, 1, 0, 1, 1, 0, 0, 0, 0);
      @(negedge clk);
      drive(1, 1, 0, 1, 1, 0, 1, 0, 0);
      #1;
      checks++; if ({bus_if.push0, bus_if.push1} !== 2'b00) begin errors++; $display("FAIL stall_cmds got %b exp 00", {bus_if.push0, bus_if.push1}); end
      @(posedge clk);
      #1;
      checks++; if (bus_if.occ !== 11'd2) begin errors++; $display("FAIL stall_occ got %0d exp 2", bus_if.occ); end
      @(negedge clk);
      drive(1, 1, 0, 1, 1, 0, 0, 1, 0);
      #1;
      checks++; if ({bus_if.push0, bus_if.push1} !== 2'b00) begin errors++; $display("FAIL flush_cmds got %b exp 00", {bus_if.push0, bus_if.push1}); end
      @(posedge clk);
      #1;
      checks++; if (bus_if.occ !== 11'd2) begin errors++; $display("FAIL flush_occ got %0d exp 2", bus_if.occ); end
      cycle(1, 1, 0, 1, 1, 0, 0, 0, 0);
      checks++; if (bus_if.occ !== 11'd4) begin errors++; $display("FAIL release_occ got %0d exp 4", bus_if.occ); end
      checks++; if (bus_if.hwm !== 11'd4) begin errors++; $display("FAIL release_hwm got %0d exp 4", bus_if.hwm); end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      drive(1, 1, 0, 1, 1, 0, 0, 0, 0);
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if ({bus_if.push0, bus_if.push1} !== 2'b00) begin errors++; $display("FAIL rst_cmds got %b exp 00", {bus_if.push0, bus_if.push1}); end
      checks++; if (bus_if.occ !== 11'd0) begin errors++; $display("FAIL rst_occ got %0d exp 0", bus_if.occ); end
      checks++; if (bus_if.hwm !== 11'd0) begin errors++; $display("FAIL rst_hwm got %0d exp 0", bus_if.hwm); end
      checks++; if (bus_if.trap !== 1'b0) begin errors++; $display("FAIL rst_trap got %0b exp 0", bus_if.trap); end
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      test_reset();
      test_push_fill();
      test_overflow();
      test_underflow();
      test_mixed();
      test_illegal();
      test_stall_flush();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
